proc_control_fsm: RTL and testbench
===================================

# proc_control_fsm

Control sequencer for the enhanced processor datapath. Accepts a 9-bit instruction from the external instruction register and steps through T0–T3 time steps. Drives the `load` enables of the general-purpose `Register` instances (R0–R7, A, G, IR) and the tri-state bus select lines. It sits directly upstream of every datapath register: each `Register` `load` input is driven from this block.

## Interface
Parameters:
- `NREG`, 8: number of general registers. The format is fixed; only 8 is supported.

Ports:
- `clk` in 1: system clock, rising edge.
- `clear` in 1: asynchronous, active-high reset.
- `run` in 1: start request; sampled only in T0.
- `ir` in 9: instruction from the IR register, format `III_XXX_YYY`.
- `g_nz` in 1: G register non-zero flag. Used only with `PROC_CTRL_MVNZ_EN`.
- `ir_load` out 1: IR register load enable.
- `r_load` out 8: one-hot R0–R7 load enables.
- `a_load` out 1: A register load enable.
- `g_load` out 1: G register load enable.
- `r_out` out 8: one-hot bus drive select for R0–R7.
- `g_out` out 1: bus drive select for G.
- `din_out` out 1: bus drive select for external DIN.
- `add_sub` out 1: ALU operation; 0 = add, 1 = subtract.
- `done` out 1: instruction-complete pulse.

## Operation
- Opcodes:
  - 000 mv Rx,Ry
  - 001 mvi Rx,#D (immediate on DIN)
  - 010 add Rx,Ry
  - 011 sub Rx,Ry
  - 110 mvnz Rx,Ry (configurable)
  - All other opcodes are illegal.
- States are T0, T1, T2, T3, in a single 2-bit register.
- All outputs decode combinationally from state, `ir`, `run` and `g_nz`. All outputs are 0 while `clear` is high.
- T0:
  - `ir_load = run`.
  - If `run`, go to T1; otherwise stay in T0.
- T1:
  - mv: `r_out[Y]`, `r_load[X]`, `done`; go to T0.
  - mvi: `din_out`, `r_load[X]`, `done`; go to T0.
  - add/sub: `r_out[X]`, `a_load`; go to T2.
  - illegal: `done` only, no loads; go to T0.
- T2 (add/sub only):
  - Assert `r_out[Y]` and `g_load`.
  - `add_sub = 1` for sub, 0 for add.
  - Go to T3.
- T3 (add/sub only):
  - Assert `g_out`, `r_load[X]` and `done`.
  - Go to T0.
- Bus rule: at most one of `r_out`, `g_out`, `din_out` is non-zero in any cycle. The bench asserts this every cycle.
- Self-moves (X = Y) are legal: the register reloads its own value.

## Timing
- Reset: state is T0 and all outputs are 0 asynchronously on `clear` rising. On release, T0 is entered in the first cycle.
- Latency from the `run` edge in T0 to `done`:
  - mv / mvi / illegal: `done` in T1, 2 cycles total.
  - add / sub: `done` in T3, 4 cycles total.
- `ir` must be stable from T1 until `done`. It is held by the IR register because `ir_load` is asserted only in T0.
- `run` is ignored in T1–T3.
- If `run` is high in the cycle after `done`, back-to-back execution follows with no idle cycle.
- `clear` asserted mid-instruction aborts the instruction immediately:
  - No further load enables are issued.
  - Registers already written keep their values.
- `done` is a single-cycle pulse. It is never asserted in T0 or T2.

## Configuration
- `PROC_CTRL_MVNZ_EN` defined: opcode 110 executes in T1.
  - If `g_nz` = 1: behaves as mv, with `r_out[Y]`, `r_load[X]` and `done`.
  - If `g_nz` = 0: `done` only.
- `PROC_CTRL_MVNZ_EN` undefined:
  - Opcode 110 is illegal: `done` only in T1.
  - `g_nz` is unused.

## Structure
- Package `proc_ctrl_pkg` holds:
  - opcode localparams (`OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`, `OP_MVNZ`);
  - state encodings (`T0`–`T3`);
  - instruction field positions (`III` = [8:6], `XXX` = [5:3], `YYY` = [2:0]).
- One sub-module, `reg_decoder`: 3-to-8 one-hot decoder with an enable. It is instantiated twice, once for X and once for Y.

## Test plan
- Reset: hold `clear` = 1 with `run` = 1.
  - Required: all outputs 0, state T0.
  - Release `clear`; next cycle `ir_load` = 1.
- mv R2,R5 (`ir` = 000_010_101):
  - T1 shows `r_out` = 8'b0010_0000, `r_load` = 8'b0000_0100, `done` = 1.
  - Then back to T0.
- sub R1,R3 (`ir` = 011_001_011):
  - T1: `r_out` = 8'h02, `a_load` = 1.
  - T2: `r_out` = 8'h08, `g_load` = 1, `add_sub` = 1.
  - T3: `g_out` = 1, `r_load` = 8'h02, `done` = 1.
- mvi R7 (`ir` = 001_111_000), back-to-back with `run` held high:
  - T1 shows `din_out` = 1, `r_load` = 8'h80, `done` = 1.
  - `ir_load` = 1 in the very next cycle.
- Abort: `clear` asserted during T2 of add R0,R4.
  - Outputs go to 0 immediately.
  - T3 never occurs and no `r_load` is issued.
- mvnz R6,R0 (`ir` = 110_110_000), with `g_nz` = 0 then `g_nz` = 1:
  - With the macro, `g_nz` = 0: `done` only.
  - With the macro, `g_nz` = 1: `r_load` = 8'h40, `r_out` = 8'h01.
  - Without the macro: `done` only in both cases.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// Shared opcodes, time-step states and instruction field positions for the
// processor control sequencer.
package proc_ctrl_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b110;

    // Instruction format III_XXX_YYY
    localparam int unsigned III_MSB = 8;
    localparam int unsigned III_LSB = 6;
    localparam int unsigned XXX_MSB = 5;
    localparam int unsigned XXX_LSB = 3;
    localparam int unsigned YYY_MSB = 2;
    localparam int unsigned YYY_LSB = 0;

endpackage

// File: rtl/reg_decoder.sv
// 3-to-8 one-hot register select decoder with an enable.
module reg_decoder (
    input  logic [2:0] sel,
    input  logic       en,
    output logic [7:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en)
            onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/proc_control_fsm.sv
// T0-T3 control sequencer for the processor datapath: register load enables
// and bus drive selects. Define PROC_CTRL_MVNZ_EN to enable the mvnz opcode.
module proc_control_fsm
    import proc_ctrl_pkg::*;
#(
    parameter int NREG = 8
) (
    input  logic            clk,
    input  logic            clear,
    input  logic            run,
    input  logic [8:0]      ir,
    input  logic            g_nz,
    output logic            ir_load,
    output logic [NREG-1:0] r_load,
    output logic            a_load,
    output logic            g_load,
    output logic [NREG-1:0] r_out,
    output logic            g_out,
    output logic            din_out,
    output logic            add_sub,
    output logic            done
);

    state_t     state;
    logic [2:0] op;
    logic [7:0] x_hot;
    logic [7:0] y_hot;
    logic       load_x;
    logic       drive_x;
    logic       drive_y;

    assign op = ir[III_MSB:III_LSB];

    reg_decoder u_x_dec (
        .sel    (ir[XXX_MSB:XXX_LSB]),
        .en     (~clear),
        .onehot (x_hot)
    );

    reg_decoder u_y_dec (
        .sel    (ir[YYY_MSB:YYY_LSB]),
        .en     (~clear),
        .onehot (y_hot)
    );

`ifndef PROC_CTRL_MVNZ_EN
    logic unused_g_nz;
    assign unused_g_nz = g_nz;
`endif

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= T0;
        end else begin
            case (state)
                T0: state <= run ? T1 : T0;
                T1: state <= (op == OP_ADD || op == OP_SUB) ? T2 : T0;
                T2: state <= T3;
                T3: state <= T0;
            endcase
        end
    end

    // Outputs are combinational so that clear blanks them immediately.
    always_comb begin
        ir_load = 1'b0;
        a_load  = 1'b0;
        g_load  = 1'b0;
        g_out   = 1'b0;
        din_out = 1'b0;
        add_sub = 1'b0;
        done    = 1'b0;
        load_x  = 1'b0;
        drive_x = 1'b0;
        drive_y = 1'b0;
        if (!clear) begin
            case (state)
                T0: ir_load = run;
                T1: begin
                    case (op)
                        OP_MV: begin
                            drive_y = 1'b1;
                            load_x  = 1'b1;
                            done    = 1'b1;
                        end
                        OP_MVI: begin
                            din_out = 1'b1;
                            load_x  = 1'b1;
                            done    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            drive_x = 1'b1;
                            a_load  = 1'b1;
                        end
`ifdef PROC_CTRL_MVNZ_EN
                        OP_MVNZ: begin
                            drive_y = g_nz;
                            load_x  = g_nz;
                            done    = 1'b1;
                        end
`endif
                        default: done = 1'b1;
                    endcase
                end
                T2: begin
                    drive_y = 1'b1;
                    g_load  = 1'b1;
                    add_sub = (op == OP_SUB);
                end
                T3: begin
                    g_out  = 1'b1;
                    load_x = 1'b1;
                    done   = 1'b1;
                end
            endcase
        end
    end

    assign r_load = load_x ? x_hot : '0;
    assign r_out  = drive_x ? x_hot : (drive_y ? y_hot : '0);

endmodule

// File: tb/tb_proc_control_fsm.sv
// Randomized self-checking bench for proc_control_fsm against a per-instruction
// micro-step trace model. Honours PROC_CTRL_MVNZ_EN like the design.
module tb_proc_control_fsm;

    logic       clk = 1'b0;
    logic       clear;
    logic       run;
    logic [8:0] ir;
    logic       g_nz;
    logic       ir_load;
    logic [7:0] r_load;
    logic       a_load;
    logic       g_load;
    logic [7:0] r_out;
    logic       g_out;
    logic       din_out;
    logic       add_sub;
    logic       done;

    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;

    logic [22:0] exp_q[$];

    proc_control_fsm #(.NREG(8)) dut (
        .clk     (clk),
        .clear   (clear),
        .run     (run),
        .ir      (ir),
        .g_nz    (g_nz),
        .ir_load (ir_load),
        .r_load  (r_load),
        .a_load  (a_load),
        .g_load  (g_load),
        .r_out   (r_out),
        .g_out   (g_out),
        .din_out (din_out),
        .add_sub (add_sub),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] observed();
        return {ir_load, r_load, a_load, g_load, r_out, g_out, din_out, add_sub, done};
    endfunction

    // One cycle of expected outputs; dst/src are register numbers, -1 for none.
    function automatic logic [22:0] mk(bit irl, int dst, int src, bit a, bit g,
                                       bit go, bit din, bit sub, bit dn);
        logic [7:0] rl;
        logic [7:0] ro;
        rl = (dst >= 0) ? 8'(1 << dst) : 8'h00;
        ro = (src >= 0) ? 8'(1 << src) : 8'h00;
        return {irl, rl, a, g, ro, go, din, sub, dn};
    endfunction

    task automatic check_vec(input string tag, input logic [22:0] obs, input logic [22:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic check_bus();
        int drivers;
        drivers = int'(r_out != 8'h00) + int'(g_out) + int'(din_out);
        check_vec("bus_rule", 23'(drivers > 1), 23'd0);
    endtask

    // Expected per-cycle trace of one instruction, starting at its T0 fetch cycle.
    task automatic build(input logic [8:0] ins, input bit gnz);
        int x;
        int y;
        x = int'(ins[5:3]);
        y = int'(ins[2:0]);
        exp_q.delete();
        exp_q.push_back(mk(1, -1, -1, 0, 0, 0, 0, 0, 0));
        case (ins[8:6])
            3'b000: exp_q.push_back(mk(0, x, y, 0, 0, 0, 0, 0, 1));
            3'b001: exp_q.push_back(mk(0, x, -1, 0, 0, 0, 1, 0, 1));
            3'b010, 3'b011: begin
                exp_q.push_back(mk(0, -1, x, 1, 0, 0, 0, 0, 0));
                exp_q.push_back(mk(0, -1, y, 0, 1, 0, 0, ins[6], 0));
                exp_q.push_back(mk(0, x, -1, 0, 0, 1, 0, 0, 1));
            end
`ifdef PROC_CTRL_MVNZ_EN
            3'b110: begin
                if (gnz) exp_q.push_back(mk(0, x, y, 0, 0, 0, 0, 0, 1));
                else     exp_q.push_back(mk(0, -1, -1, 0, 0, 0, 0, 0, 1));
            end
`endif
            default: exp_q.push_back(mk(0, -1, -1, 0, 0, 0, 0, 0, 1));
        endcase
    endtask

    // Called at posedge+1; returns at posedge+1 after the instruction's last cycle.
    task automatic exec(input string tag, input logic [8:0] ins, input bit gnz);
        build(ins, gnz);
        g_nz = gnz;
        foreach (exp_q[i]) begin
            if (i == 0) begin
                run = 1'b1;
                ir  = ins;
            end else begin
                run = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            check_vec($sformatf("%s_c%0d", tag, i), observed(), exp_q[i]);
            check_bus();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            run = 1'b0;
            ir  = 9'($urandom_range(0, 511));
            g_nz = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_vec("idle", observed(), 23'd0);
            check_bus();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [8:0] ins;
        clear = 1'b1;
        run   = 1'b1;
        ir    = 9'b000_010_101;
        g_nz  = 1'b0;

        // Reset held with run high: everything blanked.
        repeat (2) begin
            @(negedge clk);
            check_vec("reset", observed(), 23'd0);
        end
        @(posedge clk);
        #1;
        clear = 1'b0;

        exec("mv_r2_r5", 9'b000_010_101, 1'b0);
        exec("sub_r1_r3", 9'b011_001_011, 1'b0);
        idle(1);
        exec("mvi_r7", 9'b001_111_000, 1'b0);
        exec("mvi_b2b", 9'b001_111_000, 1'b1);
        exec("self_mv_r3", 9'b000_011_011, 1'b0);
        exec("add_self_r5", 9'b010_101_101, 1'b1);
        exec("illegal_111", 9'b111_001_010, 1'b1);
        exec("mvnz_gnz0", 9'b110_110_000, 1'b0);
        exec("mvnz_gnz1", 9'b110_110_000, 1'b1);
        idle(2);

        // Abort during T2 of add R0,R4.
        build(9'b010_000_100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run = (i == 0);
            ir  = 9'b010_000_100;
            @(negedge clk);
            check_vec($sformatf("abort_c%0d", i), observed(), exp_q[i]);
            if (i < 2) begin
                @(posedge clk);
                #1;
            end
        end
        clear = 1'b1;
        #1;
        check_vec("abort_now", observed(), 23'd0);
        @(posedge clk);
        #1;
        check_vec("abort_held", observed(), 23'd0);
        run   = 1'b0;
        clear = 1'b0;
        #1;
        check_vec("abort_release", observed(), 23'd0);
        @(negedge clk);
        check_vec("abort_no_t3", observed(), 23'd0);
        @(posedge clk);
        #1;
        idle(1);

        for (int n = 0; n < 300; n++) begin
            ins = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) == 0)
                ins[8:6] = 3'b110;
            exec("rand", ins, 1'($urandom_range(0, 1)));
            idle(int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule
